// File: rtl/opmac_pkg.sv
// Shared constants, state encoding and index helper for the 3x3 outer-product MAC.
package opmac_pkg;

    localparam int N         = 3;
    localparam int NUM_EL    = 9;
    localparam int DEF_DW    = 4;
    localparam int DEF_ACC_W = 10;
    localparam int IDX_W     = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_U1    = 3'd1,
        ST_U2    = 3'd2,
        ST_U3    = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    // Row-major flattening of a (row, col) pair into a result index.
    function automatic int unsigned flat_idx(input int unsigned i, input int unsigned j);
        return (i * N) + j;
    endfunction

endpackage

// File: rtl/outer_product_mac_mac_cell.sv
// Single multiply-accumulate cell: acc <= acc_clr ? 0 : acc_en ? acc + a*b : acc.
module mac_cell
    import opmac_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             acc_clr,
    input  logic             acc_en,
    input  logic [DW-1:0]    a,
    input  logic [DW-1:0]    b,
    output logic [ACC_W-1:0] acc
);

    logic [2*DW-1:0] prod_s;

    assign prod_s = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};

    // Accumulator register; clear and acc_clr both discard the running sum.
    always_ff @(posedge clk) begin
        if (clear) begin
            acc <= '0;
        end else if (acc_clr) begin
            acc <= '0;
        end else if (acc_en) begin
            acc <= acc + ACC_W'(prod_s);
        end else begin
            acc <= acc;
        end
    end

endmodule

// File: rtl/outer_product_mac.sv
// Sequences the operand bank unload strobes, accumulates C = W*X as three outer
// products, then streams the nine results row-major over valid/ready.
module outer_product_mac
    import opmac_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic [DW-1:0]    w1,
    input  logic [DW-1:0]    w2,
    input  logic [DW-1:0]    w3,
    input  logic [DW-1:0]    x1,
    input  logic [DW-1:0]    x2,
    input  logic [DW-1:0]    x3,
    output logic             unload1,
    output logic             unload2,
    output logic             unload3,
    output logic [ACC_W-1:0] res_data,
    output logic [IDX_W-1:0] res_idx,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             busy,
    output logic             done
);

    state_e             state_r;
    state_e             state_nxt_s;
    logic               start_q_r;
    logic               start_rise_s;
    logic               acc_clr_s;
    logic               acc_en_s;
    logic               accept_s;
    logic               unload1_r;
    logic               unload2_r;
    logic               unload3_r;
    logic               res_valid_r;
    logic               busy_r;
    logic               done_r;
    logic [IDX_W-1:0]   res_idx_r;
    logic [ACC_W-1:0]   res_data_s;
    logic [DW-1:0]      w_s [N];
    logic [DW-1:0]      x_s [N];
    logic [ACC_W-1:0]   acc_s [NUM_EL];

    assign w_s[0] = w1;
    assign w_s[1] = w2;
    assign w_s[2] = w3;
    assign x_s[0] = x1;
    assign x_s[1] = x2;
    assign x_s[2] = x3;

    assign start_rise_s = start & ~start_q_r;
    assign acc_clr_s    = (state_r == ST_IDLE) && start_rise_s;
    assign acc_en_s     = (state_r == ST_U1) || (state_r == ST_U2) || (state_r == ST_U3);
    assign accept_s     = res_valid_r & res_ready;

    // Cell (i,j) sees row i of the presented W column and column j of the presented X row.
    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            mac_cell #(
                .DW    (DW),
                .ACC_W (ACC_W)
            ) u_cell (
                .clk     (clk),
                .clear   (clear),
                .acc_clr (acc_clr_s),
                .acc_en  (acc_en_s),
                .a       (w_s[gi]),
                .b       (x_s[gj]),
                .acc     (acc_s[flat_idx(gi, gj)])
            );
        end
    end

    // Next-state logic; unknown encodings fall back to IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_rise_s) begin
                    state_nxt_s = ST_U1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_U1:   state_nxt_s = ST_U2;
            ST_U2:   state_nxt_s = ST_U3;
            ST_U3:   state_nxt_s = ST_DRAIN;
            ST_DRAIN: begin
                if (accept_s && (res_idx_r == 4'd8)) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, edge detector, index counter and flags decoded from the next state.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_r     <= ST_IDLE;
            start_q_r   <= 1'b0;
            res_idx_r   <= 4'd0;
            unload1_r   <= 1'b0;
            unload2_r   <= 1'b0;
            unload3_r   <= 1'b0;
            res_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            start_q_r   <= start;
            if (accept_s) begin
                res_idx_r <= (res_idx_r == 4'd8) ? 4'd0 : (res_idx_r + 4'd1);
            end else begin
                res_idx_r <= res_idx_r;
            end
            unload1_r   <= (state_nxt_s == ST_U1);
            unload2_r   <= (state_nxt_s == ST_U2);
            unload3_r   <= (state_nxt_s == ST_U3);
            res_valid_r <= (state_nxt_s == ST_DRAIN);
            busy_r      <= (state_nxt_s != ST_IDLE);
            done_r      <= (state_nxt_s == ST_DONE);
        end
    end

    // Result mux over the accumulator array.
    always_comb begin
        res_data_s = '0;
        if (res_idx_r <= 4'd8) begin
            res_data_s = acc_s[res_idx_r];
        end else begin
            res_data_s = '0;
        end
    end

    assign unload1   = unload1_r;
    assign unload2   = unload2_r;
    assign unload3   = unload3_r;
    assign res_valid = res_valid_r;
    assign res_idx   = res_idx_r;
    assign res_data  = res_data_s;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_outer_product_mac.sv
// Directed self-checking bench for outer_product_mac with a behavioural operand bank.
module tb_outer_product_mac;

    logic       clk;
    logic       clear;
    logic       start;
    logic [3:0] w1, w2, w3, x1, x2, x3;
    logic       unload1, unload2, unload3;
    logic [9:0] res_data;
    logic [3:0] res_idx;
    logic       res_valid;
    logic       res_ready;
    logic       busy;
    logic       done;

    logic [3:0] wm [9];
    logic [3:0] xm [9];

    int n_cmp = 0;
    int n_bad = 0;

    int unl_first [3];
    int unl_cnt   [3];
    int out_data  [$];
    int out_idx   [$];
    int done_cyc, done_cnt, busy_cnt, busy_end, stall_viol;

    outer_product_mac #(.DW(4), .ACC_W(10)) dut (
        .clk       (clk),
        .clear     (clear),
        .start     (start),
        .w1        (w1),
        .w2        (w2),
        .w3        (w3),
        .x1        (x1),
        .x2        (x2),
        .x3        (x3),
        .unload1   (unload1),
        .unload2   (unload2),
        .unload3   (unload3),
        .res_data  (res_data),
        .res_idx   (res_idx),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bank model: column k of W and row k of X while unload(k+1) is high.
    always_comb begin
        w1 = 4'd0; w2 = 4'd0; w3 = 4'd0;
        x1 = 4'd0; x2 = 4'd0; x3 = 4'd0;
        for (int k = 0; k < 3; k++) begin
            if ((k == 0 && unload1) || (k == 1 && unload2) || (k == 2 && unload3)) begin
                w1 = wm[k]; w2 = wm[3 + k]; w3 = wm[6 + k];
                x1 = xm[3 * k]; x2 = xm[3 * k + 1]; x3 = xm[3 * k + 2];
            end
        end
    end

    task automatic start_edge();
        start = 1'b0;
        @(posedge clk);
        #1 start = 1'b1;
    endtask

    // Observes one run: cycle c is the c-th cycle after the start-sampling edge.
    task automatic collect(input int max_cyc, input int duty, input int tog_cyc);
        logic [9:0] held_d;
        logic [3:0] held_i;
        logic       held;
        for (int k = 0; k < 3; k++) begin
            unl_first[k] = 0;
            unl_cnt[k]   = 0;
        end
        out_data.delete();
        out_idx.delete();
        done_cyc = 0; done_cnt = 0; busy_cnt = 0; busy_end = 0; stall_viol = 0;
        held = 1'b0; held_d = 10'd0; held_i = 4'd0;
        @(posedge clk);
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge clk);
            if (c == tog_cyc) start = 1'b0;
            if (c == tog_cyc + 1) start = 1'b1;
            res_ready = (duty <= 1) ? 1'b1 : ((c % duty) == 0);
            if (unload1) begin unl_cnt[0]++; if (unl_first[0] == 0) unl_first[0] = c; end
            if (unload2) begin unl_cnt[1]++; if (unl_first[1] == 0) unl_first[1] = c; end
            if (unload3) begin unl_cnt[2]++; if (unl_first[2] == 0) unl_first[2] = c; end
            if (busy) busy_cnt++;
            if (held && (res_data !== held_d || res_idx !== held_i)) stall_viol++;
            held = 1'b0;
            if (res_valid && res_ready) begin
                out_data.push_back(int'(res_data));
                out_idx.push_back(int'(res_idx));
            end else if (res_valid) begin
                held = 1'b1; held_d = res_data; held_i = res_idx;
            end
            if (done) begin done_cnt++; if (done_cyc == 0) done_cyc = c; end
            busy_end = int'(busy);
        end
    endtask

    task automatic test_reset();
        clear = 1'b1; start = 1'b0; res_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if ({unload1, unload2, unload3} !== 3'b000) begin n_bad++; $display("FAIL reset_unload got=%b want=000", {unload1, unload2, unload3}); end
        n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b want=0", res_valid); end
        n_cmp++; if (res_idx !== 4'd0) begin n_bad++; $display("FAIL reset_idx got=%0d want=0", res_idx); end
        n_cmp++; if ({busy, done} !== 2'b00) begin n_bad++; $display("FAIL reset_busy_done got=%b want=00", {busy, done}); end
        clear = 1'b0;
    endtask

    task automatic test_identity();
        for (int k = 0; k < 9; k++) begin
            wm[k] = (k == 0 || k == 4 || k == 8) ? 4'd1 : 4'd0;
            xm[k] = 4'(k + 1);
        end
        start_edge();
        collect(20, 1, -5);
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (unl_first[k] != k + 1 || unl_cnt[k] != 1) begin n_bad++; $display("FAIL id_unload%0d first=%0d cnt=%0d want first=%0d cnt=1", k + 1, unl_first[k], unl_cnt[k], k + 1); end
        end
        n_cmp++; if (out_data.size() != 9) begin n_bad++; $display("FAIL id_count got=%0d want=9", out_data.size()); end
        for (int k = 0; k < 9; k++) begin
            n_cmp++;
            if (k >= out_data.size() || out_data[k] != k + 1 || out_idx[k] != k) begin
                n_bad++; $display("FAIL id_elem%0d got=%0d@%0d want=%0d@%0d", k, (k < out_data.size()) ? out_data[k] : -1, (k < out_idx.size()) ? out_idx[k] : -1, k + 1, k);
            end
        end
        n_cmp++; if (done_cyc != 13 || done_cnt != 1) begin n_bad++; $display("FAIL id_done cyc=%0d cnt=%0d want cyc=13 cnt=1", done_cyc, done_cnt); end
    endtask

    task automatic test_max_operands();
        for (int k = 0; k < 9; k++) begin wm[k] = 4'd15; xm[k] = 4'd15; end
        start_edge();
        collect(20, 1, -5);
        n_cmp++; if (out_data.size() != 9) begin n_bad++; $display("FAIL max_count got=%0d want=9", out_data.size()); end
        for (int k = 0; k < 9; k++) begin
            n_cmp++;
            if (k >= out_data.size() || out_data[k] != 675) begin
                n_bad++; $display("FAIL max_elem%0d got=%0d want=675", k, (k < out_data.size()) ? out_data[k] : -1);
            end
        end
    endtask

    task automatic test_backpressure();
        int exp_d [9] = '{30, 24, 18, 84, 69, 54, 138, 114, 90};
        for (int k = 0; k < 9; k++) begin wm[k] = 4'(k + 1); xm[k] = 4'(9 - k); end
        start_edge();
        collect(45, 3, -5);
        n_cmp++; if (out_data.size() != 9) begin n_bad++; $display("FAIL bp_count got=%0d want=9", out_data.size()); end
        for (int k = 0; k < 9; k++) begin
            n_cmp++;
            if (k >= out_data.size() || out_data[k] != exp_d[k] || out_idx[k] != k) begin
                n_bad++; $display("FAIL bp_elem%0d got=%0d@%0d want=%0d@%0d", k, (k < out_data.size()) ? out_data[k] : -1, (k < out_idx.size()) ? out_idx[k] : -1, exp_d[k], k);
            end
        end
        n_cmp++; if (stall_viol != 0) begin n_bad++; $display("FAIL bp_hold got=%0d changes want=0", stall_viol); end
        n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL bp_done got=%0d pulses want=1", done_cnt); end
    endtask

    task automatic test_no_retrigger();
        int exp_d [9] = '{24, 30, 36, 24, 30, 36, 24, 30, 36};
        collect(15, 1, -5);
        n_cmp++; if (unl_cnt[0] + unl_cnt[1] + unl_cnt[2] != 0 || busy_cnt != 0) begin n_bad++; $display("FAIL level_start unloads=%0d busy=%0d want 0 0", unl_cnt[0] + unl_cnt[1] + unl_cnt[2], busy_cnt); end
        start_edge();
        collect(30, 1, 6);
        n_cmp++; if (unl_cnt[0] != 1 || unl_cnt[1] != 1 || unl_cnt[2] != 1) begin n_bad++; $display("FAIL drain_edge_unloads got=%0d/%0d/%0d want=1/1/1", unl_cnt[0], unl_cnt[1], unl_cnt[2]); end
        n_cmp++; if (out_data.size() != 9 || done_cnt != 1) begin n_bad++; $display("FAIL drain_edge_out count=%0d done=%0d want 9 1", out_data.size(), done_cnt); end
        n_cmp++; if (busy_cnt != 13 || busy_end != 0) begin n_bad++; $display("FAIL drain_edge_busy cycles=%0d end=%0d want 13 0", busy_cnt, busy_end); end
        for (int k = 0; k < 9; k++) begin wm[k] = 4'd2; xm[k] = 4'(k + 1); end
        start_edge();
        collect(20, 1, -5);
        n_cmp++; if (out_data.size() != 9) begin n_bad++; $display("FAIL rerun_count got=%0d want=9", out_data.size()); end
        for (int k = 0; k < 9; k++) begin
            n_cmp++;
            if (k >= out_data.size() || out_data[k] != exp_d[k]) begin
                n_bad++; $display("FAIL rerun_elem%0d got=%0d want=%0d", k, (k < out_data.size()) ? out_data[k] : -1, exp_d[k]);
            end
        end
    endtask

    task automatic test_clear_u2();
        int exp_d [9] = '{30, 24, 18, 84, 69, 54, 138, 114, 90};
        for (int k = 0; k < 9; k++) begin wm[k] = 4'd15; xm[k] = 4'd15; end
        start_edge();
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (unload2 !== 1'b1) begin n_bad++; $display("FAIL clr_u2_in_u2 got=%b want=1", unload2); end
        clear = 1'b1; start = 1'b0;
        @(negedge clk);
        n_cmp++; if ({unload1, unload2, unload3, res_valid, busy, done} !== 6'd0 || res_idx !== 4'd0) begin n_bad++; $display("FAIL clr_u2_outputs got=%b idx=%0d want=000000 idx=0", {unload1, unload2, unload3, res_valid, busy, done}, res_idx); end
        clear = 1'b0;
        for (int k = 0; k < 9; k++) begin wm[k] = 4'(k + 1); xm[k] = 4'(9 - k); end
        start_edge();
        collect(20, 1, -5);
        n_cmp++; if (done_cyc != 13) begin n_bad++; $display("FAIL clr_u2_done got=%0d want=13", done_cyc); end
        for (int k = 0; k < 9; k++) begin
            n_cmp++;
            if (k >= out_data.size() || out_data[k] != exp_d[k]) begin
                n_bad++; $display("FAIL clr_u2_elem%0d got=%0d want=%0d", k, (k < out_data.size()) ? out_data[k] : -1, exp_d[k]);
            end
        end
    endtask

    task automatic test_clear_drain();
        bit found = 1'b0;
        for (int k = 0; k < 9; k++) begin wm[k] = 4'd15; xm[k] = 4'd15; end
        res_ready = 1'b1;
        start_edge();
        @(posedge clk);
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (res_valid && res_idx == 4'd4) found = 1'b1;
        end
        n_cmp++; if (!found) begin n_bad++; $display("FAIL clr_drain_reach got=timeout want=idx4"); end
        clear = 1'b1; start = 1'b0;
        @(negedge clk);
        n_cmp++; if ({unload1, unload2, unload3, res_valid, busy, done} !== 6'd0 || res_idx !== 4'd0) begin n_bad++; $display("FAIL clr_drain_outputs got=%b idx=%0d want=000000 idx=0", {unload1, unload2, unload3, res_valid, busy, done}, res_idx); end
        clear = 1'b0;
        for (int k = 0; k < 9; k++) begin
            wm[k] = (k == 0 || k == 4 || k == 8) ? 4'd1 : 4'd0;
            xm[k] = 4'(k + 1);
        end
        start_edge();
        collect(20, 1, -5);
        n_cmp++; if (out_data.size() != 9) begin n_bad++; $display("FAIL clr_drain_count got=%0d want=9", out_data.size()); end
        for (int k = 0; k < 9; k++) begin
            n_cmp++;
            if (k >= out_data.size() || out_data[k] != k + 1 || out_idx[k] != k) begin
                n_bad++; $display("FAIL clr_drain_elem%0d got=%0d want=%0d", k, (k < out_data.size()) ? out_data[k] : -1, k + 1);
            end
        end
    endtask

    initial begin
        clear = 1'b1; start = 1'b0; res_ready = 1'b0;
        for (int k = 0; k < 9; k++) begin wm[k] = 4'd0; xm[k] = 4'd0; end
        test_reset();
        test_identity();
        test_max_operands();
        test_backpressure();
        test_no_retrigger();
        test_clear_u2();
        test_clear_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/outer_product_mac.md
Name: outer_product_mac

Overview:
- Consumer stage directly downstream of the 3x3 operand memory bank.
- Sequences the bank's unload1/unload2/unload3 strobes. Each step k presents column k of W and row k of X.
- Accumulates the three outer products into a 3x3 result C = W*X, then streams the 9 results row-major over a valid/ready handshake.

Parameters:
- DW, 4, operand width; must match the bank's data width.
- ACC_W, 10, accumulator width. Must be >= 2*DW+2 so that 3 x (2^DW-1)^2 fits (675 at DW=4).

Ports:
- clk  in  1  rising-edge clock
- clear  in  1  synchronous active-high reset
- start  in  1  from bank; level "operands loaded"; a rising edge triggers a run
- w1, w2, w3  in  DW each  bank data_outw1..3 (W column k, rows 0..2)
- x1, x2, x3  in  DW each  bank data_outx1..3 (X row k, cols 0..2)
- unload1, unload2, unload3  out  1 each  to bank; one-hot or all zero
- res_data  out  ACC_W  current result element C[res_idx]
- res_idx  out  4  element index 0..8, row-major (idx = 3*i + j)
- res_valid  out  1  res_data/res_idx valid
- res_ready  in  1  downstream accepts when valid && ready
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse after the last element is accepted

Behaviour:
- Reset, clear=1 at a clock edge:
  - state=IDLE; all 9 accumulators = 0; start_q = 0.
  - unload1..3 = 0, res_valid = 0, res_idx = 0, done = 0, busy = 0.
  - Applies from any state, including mid-unload and mid-drain. A partial run is discarded.
- Start detection:
  - start_q registers start every cycle; start_rise = start && !start_q.
  - A level-high start never retriggers.
  - start_rise outside IDLE is ignored; it is not queued.
- States: IDLE, U1, U2, U3, DRAIN, DONE.
- IDLE:
  - On start_rise, all accumulators clear to 0 and the next state is U1.
- U1, U2, U3 (one cycle each):
  - unloadk = 1 only in state Uk (Moore-decoded, registered state).
  - The bank's outputs respond combinationally within the same cycle.
  - At the closing edge of Uk, for all i,j: acc[i][j] <= acc[i][j] + w(i+1) * x(j+1). Products are unsigned DW x DW -> 2*DW bits, zero-extended to ACC_W.
  - Transitions: U1 -> U2 -> U3 -> DRAIN unconditionally.
- DRAIN:
  - res_valid = 1; res_data = acc[res_idx/3][res_idx%3].
  - On valid && ready: res_idx increments. When res_idx == 8 is accepted, go to DONE and reset res_idx to 0.
  - With res_ready = 0, res_data and res_idx hold stable.
- DONE:
  - done = 1 for exactly one cycle, then IDLE.
  - Accumulators retain the result until the next start_rise.
- Latency:
  - start_rise sampled at edge t -> unload1 high in cycle t+1.
  - First res_valid in cycle t+4.
  - With res_ready held high, done is high in cycle t+13.
- Overflow: unreachable for ACC_W >= 2*DW+2. No saturation logic.
- Unknown or illegal state encoding -> IDLE.

Decomposition:
- Package opmac_pkg:
  - state enum (IDLE, U1, U2, U3, DRAIN, DONE);
  - N = 3 and NUM_EL = 9;
  - default DW and ACC_W constants.
- One sub-module, mac_cell:
  - ports: clk, clear (sync), acc_clr, acc_en, a[DW], b[DW], acc[ACC_W];
  - computes acc <= acc_clr ? 0 : acc_en ? acc + a*b : acc;
  - instantiated 9 times via generate over i,j.
- Top level holds the FSM, start edge detect, and output mux.

Test Plan:
- W = identity, X = 1..9 row-major, start 0 -> 1 held, res_ready = 1:
  - unload1, unload2, unload3 each high exactly one cycle, in order;
  - res_data sequence 1,2,3,4,5,6,7,8,9 with res_idx 0..8;
  - done pulses once, 13 cycles after the start edge.
- W = X = all 15 -> all 9 results = 675 (0x2A3); no wrap.
- W = 1..9, X = 9..1 -> results 30,24,18,84,69,54,138,114,90.
  - Drive res_ready with a 1-of-3 duty pattern.
  - Data and index must hold while not ready; no element is duplicated or skipped.
- start held high after done, plus a second rising edge during DRAIN -> no new run; busy falls after done.
  - Then start 1 -> 0 -> 1 -> a new run with accumulators cleared; results equal the new operands only.
- clear asserted during U2, and separately during DRAIN at res_idx = 4:
  - next cycle state is IDLE with all outputs at reset values;
  - a following start edge produces correct results with no residue.
